// File: rtl/triangle_pkg.sv
// Shared types and register map for the triangle-check Avalon master.
package triangle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_A,
      WR_B,
      WR_C,
      RD_RES,
      RD_WAIT,
      OUT
   } tc_state_e;

   localparam logic [1:0] ADDR_A      = 2'd0;
   localparam logic [1:0] ADDR_B      = 2'd1;
   localparam logic [1:0] ADDR_C      = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

endpackage

// File: rtl/triangle_check_master_stall_timer.sv
// Counts consecutive stalled cycles of one Avalon command; flags the cycle
// whose stall brings the count to TIMEOUT. TIMEOUT=0 never expires.
module avm_stall_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic incr_i,
   output logic expired_o
);

   localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (incr_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry fires on the stalled cycle that would make the count reach TIMEOUT.
   assign expired_o = (TIMEOUT != 0) && incr_i && (count_q == LAST);

endmodule

// File: rtl/triangle_check_master.sv
// Avalon-MM master: writes a triangle triple to the checker slave, reads
// RESULT, and returns the verdict on a valid/ready stream.
module triangle_check_master
   import triangle_pkg::*;
#(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned TIMEOUT      = 255,
   parameter int unsigned STAT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [DATA_W-1:0] in_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_is_tri,
   output logic              out_error,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [STAT_W-1:0] stat_total,
   output logic [STAT_W-1:0] stat_tri,
   output tc_state_e         dbg_state
);

   // Handshake rule for both streams: a transfer happens at a rising edge
   // where valid and ready are both 1; valid never waits on ready.

   localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

   tc_state_e         state_q, state_d;
   logic [DATA_W-1:0] b_q, b_d, c_q, c_d;
   logic [1:0]        lat_q, lat_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic [1:0]        addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              valid_q, valid_d, tri_q, tri_d, err_q, err_d;
   logic [STAT_W-1:0] total_q, total_d, ntri_q, ntri_d;
   logic              stalled, expired;
   logic              unused_rdata;

   assign stalled      = (rd_q | wr_q) & avm_waitrequest;
   assign unused_rdata = ^avm_readdata[DATA_W-1:1];

   avm_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (!stalled),
      .incr_i    (stalled),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      c_d     = c_q;
      lat_d   = lat_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      valid_d = valid_q;
      tri_d   = tri_q;
      err_d   = err_q;
      total_d = total_q;
      ntri_d  = ntri_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               b_d     = in_b;
               c_d     = in_c;
               wr_d    = 1'b1;
               addr_d  = ADDR_A;
               wdata_d = in_a;
               state_d = WR_A;
            end
         end
         WR_A: begin
            if (!avm_waitrequest) begin
               addr_d  = ADDR_B;
               wdata_d = b_q;
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (!avm_waitrequest) begin
               addr_d  = ADDR_C;
               wdata_d = c_q;
               state_d = WR_C;
            end
         end
         WR_C: begin
            if (!avm_waitrequest) begin
               wr_d    = 1'b0;
               rd_d    = 1'b1;
               addr_d  = ADDR_RESULT;
               state_d = RD_RES;
            end
         end
         RD_RES: begin
            if (!avm_waitrequest) begin
               rd_d    = 1'b0;
               lat_d   = '0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (lat_q == LAT_LAST) begin
               tri_d   = avm_readdata[0];
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
               if (total_q != '1) total_d = total_q + 1'b1;
               if (tri_q && !err_q && (ntri_q != '1)) ntri_d = ntri_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Expiry only happens while a command is stalled, so it never races acceptance.
      if (expired) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         tri_d   = 1'b0;
         err_d   = 1'b1;
         valid_d = 1'b1;
         state_d = OUT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         b_q     <= '0;
         c_q     <= '0;
         lat_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         valid_q <= 1'b0;
         tri_q   <= 1'b0;
         err_q   <= 1'b0;
         total_q <= '0;
         ntri_q  <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         c_q     <= c_d;
         lat_q   <= lat_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         tri_q   <= tri_d;
         err_q   <= err_d;
         total_q <= total_d;
         ntri_q  <= ntri_d;
      end
   end

   assign in_ready      = (state_q == IDLE);
   assign out_valid     = valid_q;
   assign out_is_tri    = tri_q;
   assign out_error     = err_q;
   assign avm_address   = addr_q;
   assign avm_read      = rd_q;
   assign avm_write     = wr_q;
   assign avm_writedata = wdata_q;
   assign stat_total    = total_q;
   assign stat_tri      = ntri_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_triangle_check_master.sv
// Directed bench for triangle_check_master with an Avalon slave model and
// queue-based scoreboards for bus commands and verdicts.
module tb_triangle_check_master;
   import triangle_pkg::*;

   localparam int DW = 32;
   localparam int LIMIT = 3000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_a = '0, in_b = '0, in_c = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          out_is_tri, out_error;
   logic [1:0]    avm_address;
   logic          avm_read, avm_write;
   logic [DW-1:0] avm_writedata;
   logic          avm_waitrequest = 1'b0;
   logic [DW-1:0] avm_readdata = '0;
   logic [15:0]   stat_total, stat_tri;
   tc_state_e     dbg_state;

   int n_checks = 0;
   int n_err = 0;

   logic [1:0]  exp_q[$];   // {error, is_tri}
   logic [34:0] bus_q[$];   // {is_write, address, data}

   // Slave model state
   logic [DW-1:0] regs[4];
   logic          rd_v = 1'b0;
   bit            rd_pend = 0;
   int            stall_cnt = 0;
   int            stall_target = 1;
   bit            hold_arm = 0;
   int            hold_cycles = 0;
   int            stall_b = 0;
   int            rd_cycles = 0;

   triangle_check_master #(
      .DATA_W(DW), .READ_LATENCY(1), .TIMEOUT(255), .STAT_W(16)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_is_tri(out_is_tri), .out_error(out_error),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .stat_total(stat_total), .stat_tri(stat_tri),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_ev(input string name, input logic [63:0] act);
      n_checks++;
      n_err++;
      $display("FAIL %s: got %0h, expected nothing", name, act);
   endtask

   function automatic logic tri_ok(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c);
      longint sa, sb, sc;
      sa = longint'(a);
      sb = longint'(b);
      sc = longint'(c);
      return (sa + sb > sc) && (sa + sc > sb) && (sb + sc > sa);
   endfunction

   // ---------------- Avalon slave model + bus monitor ----------------
   always begin
      @(posedge clk);
      #1;
      if (hold_arm && avm_write && (avm_address == 2'd1)) begin
         hold_cycles = 300;
         hold_arm = 0;
      end
      if (hold_cycles > 0) begin
         avm_waitrequest = 1'b1;
         hold_cycles--;
      end else if (avm_write || avm_read) begin
         if (stall_cnt < stall_target) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
         end else begin
            avm_waitrequest = 1'b0;
         end
      end else begin
         avm_waitrequest = 1'b0;
         stall_cnt = 0;
      end
      // Valid data only in the one cycle the master must sample; junk otherwise.
      if (rd_pend) begin
         avm_readdata = {31'h2AAA_AAAA, rd_v};
         rd_pend = 0;
      end else begin
         avm_readdata = {31'h1555_5555, ~rd_v};
      end

      @(negedge clk);
      if (!reset) begin
         if (avm_write && avm_waitrequest && (avm_address == 2'd1)) stall_b++;
         if (avm_read) rd_cycles++;
         if ((avm_write || avm_read) && !avm_waitrequest) begin
            logic [34:0] op;
            op = avm_write ? {1'b1, avm_address, avm_writedata} : {1'b0, avm_address, 32'h0};
            if (avm_write) begin
               regs[avm_address] = avm_writedata;
            end else begin
               rd_v = tri_ok(regs[0], regs[1], regs[2]);
               rd_pend = 1;
            end
            stall_cnt = 0;
            if (bus_q.size() == 0) fail_ev("bus_unexpected", 64'(op));
            else check("bus_op", 64'(op), 64'(bus_q.pop_front()));
         end
      end
   end

   // ---------------- verdict monitor ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) fail_ev("verdict_unexpected", {62'd0, out_error, out_is_tri});
         else check("verdict", {62'd0, out_error, out_is_tri}, 64'(exp_q.pop_front()));
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                       input logic exp_tri, input logic exp_err, input bit keep);
      int n;
      in_a = a;
      in_b = b;
      in_c = c;
      in_valid = 1'b1;
      exp_q.push_back({exp_err, exp_tri});
      bus_q.push_back({1'b1, 2'd0, a});
      bus_q.push_back({1'b1, 2'd1, b});
      bus_q.push_back({1'b1, 2'd2, c});
      bus_q.push_back({1'b0, 2'd3, 32'h0});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < LIMIT);
      if (!in_ready) fail_ev("in_handshake_timeout", 64'(n));
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) begin
         fail_ev(name, 64'(exp_q.size()));
         exp_q.delete();
         bus_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      bus_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      bit ok;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_avm_cmd", {62'd0, avm_read, avm_write}, 64'd0);
      check("rst_avm_addr_data", {avm_address, avm_writedata}, 64'd0);
      check("rst_verdict", {62'd0, out_is_tri, out_error}, 64'd0);
      check("rst_stats", {stat_total, stat_tri}, 64'd0);
      @(posedge clk);
      #1;

      // 1: valid triangle, one stall cycle per command
      send(3, 4, 5, 1'b1, 1'b0, 0);
      wait_idle("t1_timeout");
      check("t1_stat_total", 64'(stat_total), 64'd1);
      check("t1_stat_tri", 64'(stat_tri), 64'd1);

      // 2: degenerate triple
      send(1, 2, 3, 1'b0, 1'b0, 0);
      wait_idle("t2_timeout");
      check("t2_stat_total", 64'(stat_total), 64'd2);
      check("t2_stat_tri", 64'(stat_tri), 64'd1);

      // 3: write B stalled beyond the timeout
      stall_b = 0;
      rd_cycles = 0;
      hold_arm = 1;
      send(6, 7, 8, 1'b0, 1'b1, 0);
      n = 0;
      while (exp_q.size() != 0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) fail_ev("t3_verdict_timeout", 64'(n));
      @(posedge clk);
      #1;
      check("t3_unissued_cmds", 64'(bus_q.size()), 64'd3);
      bus_q.delete();
      check("t3_stalled_cycles", 64'(stall_b), 64'd255);
      check("t3_read_cycles", 64'(rd_cycles), 64'd0);
      check("t3_stat_total", 64'(stat_total), 64'd3);
      check("t3_stat_tri", 64'(stat_tri), 64'd1);
      n = 0;
      while (hold_cycles > 0 && n < LIMIT) begin
         @(posedge clk);
         n++;
      end
      #1;

      // 4: consumer back-pressure for 10 cycles
      out_ready = 1'b0;
      send(5, 12, 13, 1'b1, 1'b0, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < LIMIT);
      check("t4_out_valid_seen", 64'(out_valid), 64'd1);
      ok = 1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         if (!(out_valid && out_is_tri && !out_error && !in_ready && !avm_read && !avm_write))
            ok = 0;
      end
      check("t4_hold_stable", 64'(ok), 64'd1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle("t4_timeout");
      check("t4_in_ready", 64'(in_ready), 64'd1);
      check("t4_stat_total", 64'(stat_total), 64'd4);
      check("t4_stat_tri", 64'(stat_tri), 64'd2);

      // 5: reset while WR_C is stalled
      stall_target = 5;
      send(2, 3, 4, 1'b1, 1'b0, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dbg_state != WR_C && n < LIMIT);
      check("t5_reached_wr_c", 64'(dbg_state), 64'(WR_C));
      pulse_reset();
      @(negedge clk);
      check("t5_avm_write", 64'(avm_write), 64'd0);
      check("t5_in_ready", 64'(in_ready), 64'd1);
      check("t5_stats", {stat_total, stat_tri}, 64'd0);
      stall_target = 1;
      @(posedge clk);
      #1;
      send(5, 5, 5, 1'b1, 1'b0, 0);
      wait_idle("t5_timeout");
      check("t5_stat_total", 64'(stat_total), 64'd1);
      check("t5_stat_tri", 64'(stat_tri), 64'd1);

      // 6: back-to-back triples with in_valid held high
      pulse_reset();
      send(3, 4, 5, 1'b1, 1'b0, 1);
      send(1, 1, 5, 1'b0, 1'b0, 1);
      send(7, 7, 7, 1'b1, 1'b0, 0);
      wait_idle("t6_timeout");
      check("t6_stat_total", 64'(stat_total), 64'd3);
      check("t6_stat_tri", 64'(stat_tri), 64'd2);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
